// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: captures MEM-stage results for write-back, with stall,
// flush (bubble) and a retired-instruction counter.
module mem_wb_pipe_reg #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic                      In_Valid,
  input  logic [DATA_WIDTH-1:0]     In_ALUResult,
  input  logic [DATA_WIDTH-1:0]     In_MemReadData,
  input  logic                      In_RegWrite,
  input  logic                      In_MemToReg,
  input  logic [REG_ADDR_WIDTH-1:0] In_WriteReg,
  output logic                      Out_Valid,
  output logic [DATA_WIDTH-1:0]     Out_ALUResult,
  output logic [DATA_WIDTH-1:0]     Out_MemReadData,
  output logic                      Out_RegWrite,
  output logic                      Out_MemToReg,
  output logic [REG_ADDR_WIDTH-1:0] Out_WriteReg,
  output logic [CNT_WIDTH-1:0]      Out_RetireCount
);

  logic                      valid_d;
  logic [DATA_WIDTH-1:0]     alu_d;
  logic [DATA_WIDTH-1:0]     mem_d;
  logic                      regwrite_d;
  logic                      memtoreg_d;
  logic [REG_ADDR_WIDTH-1:0] writereg_d;
  logic [CNT_WIDTH-1:0]      cnt_d;

  // Next-stage contents: flush loads a bubble, stall holds, otherwise load.
  always_comb begin
    valid_d    = Out_Valid;
    alu_d      = Out_ALUResult;
    mem_d      = Out_MemReadData;
    regwrite_d = Out_RegWrite;
    memtoreg_d = Out_MemToReg;
    writereg_d = Out_WriteReg;
    cnt_d      = Out_RetireCount;
    if (Flush) begin
      valid_d    = 1'b0;
      alu_d      = '0;
      mem_d      = '0;
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      writereg_d = '0;
    end else if (!Stall) begin
      valid_d    = In_Valid;
      alu_d      = In_ALUResult;
      mem_d      = In_MemReadData;
      // Writes to $zero or from empty slots never reach the register file.
      regwrite_d = In_RegWrite & In_Valid & (In_WriteReg != '0);
      memtoreg_d = In_MemToReg;
      writereg_d = In_WriteReg;
      if (In_Valid) cnt_d = Out_RetireCount + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Out_Valid       <= 1'b0;
      Out_ALUResult   <= '0;
      Out_MemReadData <= '0;
      Out_RegWrite    <= 1'b0;
      Out_MemToReg    <= 1'b0;
      Out_WriteReg    <= '0;
      Out_RetireCount <= '0;
    end else begin
      Out_Valid       <= valid_d;
      Out_ALUResult   <= alu_d;
      Out_MemReadData <= mem_d;
      Out_RegWrite    <= regwrite_d;
      Out_MemToReg    <= memtoreg_d;
      Out_WriteReg    <= writereg_d;
      Out_RetireCount <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Randomized bench for mem_wb_pipe_reg against a behavioural model; a second
// instance with a 3-bit counter exercises counter wrap.
module tb_mem_wb_pipe_reg;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall, Flush, In_Valid, In_RegWrite, In_MemToReg;
  logic [31:0] In_ALUResult, In_MemReadData;
  logic [4:0]  In_WriteReg;

  logic        o_valid, o_rw, o_m2r;
  logic [31:0] o_alu, o_mem, o_cnt;
  logic [4:0]  o_wr;

  logic        s_valid, s_rw, s_m2r;
  logic [31:0] s_alu, s_mem;
  logic [4:0]  s_wr;
  logic [2:0]  s_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model state
  logic        m_valid, m_rw, m_m2r;
  logic [31:0] m_alu, m_mem;
  logic [4:0]  m_wr;
  longint unsigned m_cnt;

  always #5 Clk = ~Clk;

  mem_wb_pipe_reg dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .In_Valid(In_Valid),
    .In_ALUResult(In_ALUResult), .In_MemReadData(In_MemReadData),
    .In_RegWrite(In_RegWrite), .In_MemToReg(In_MemToReg), .In_WriteReg(In_WriteReg),
    .Out_Valid(o_valid), .Out_ALUResult(o_alu), .Out_MemReadData(o_mem),
    .Out_RegWrite(o_rw), .Out_MemToReg(o_m2r), .Out_WriteReg(o_wr),
    .Out_RetireCount(o_cnt)
  );

  mem_wb_pipe_reg #(.CNT_WIDTH(3)) dut_small (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .In_Valid(In_Valid),
    .In_ALUResult(In_ALUResult), .In_MemReadData(In_MemReadData),
    .In_RegWrite(In_RegWrite), .In_MemToReg(In_MemToReg), .In_WriteReg(In_WriteReg),
    .Out_Valid(s_valid), .Out_ALUResult(s_alu), .Out_MemReadData(s_mem),
    .Out_RegWrite(s_rw), .Out_MemToReg(s_m2r), .Out_WriteReg(s_wr),
    .Out_RetireCount(s_cnt)
  );

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_m2r = 0; m_alu = 0; m_mem = 0; m_wr = 0; m_cnt = 0;
  endtask

  // Apply the edge rules to the inputs that were present at the edge.
  task automatic model_edge();
    if (Flush) begin
      m_valid = 0; m_rw = 0; m_m2r = 0; m_alu = 0; m_mem = 0; m_wr = 0;
    end else if (!Stall) begin
      m_valid = In_Valid;
      m_alu   = In_ALUResult;
      m_mem   = In_MemReadData;
      m_m2r   = In_MemToReg;
      m_wr    = In_WriteReg;
      m_rw    = In_RegWrite && In_Valid && (In_WriteReg != 5'd0);
      if (In_Valid) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check_all();
    cmp("valid",    64'(o_valid), 64'(m_valid));
    cmp("alu",      64'(o_alu),   64'(m_alu));
    cmp("memdata",  64'(o_mem),   64'(m_mem));
    cmp("regwrite", 64'(o_rw),    64'(m_rw));
    cmp("memtoreg", 64'(o_m2r),   64'(m_m2r));
    cmp("writereg", 64'(o_wr),    64'(m_wr));
    cmp("count",    64'(o_cnt),   m_cnt % 64'h1_0000_0000);
    cmp("count3",   64'(s_cnt),   m_cnt % 64'd8);
    cmp("valid3",   64'(s_valid), 64'(m_valid));
    cmp("rw3",      64'(s_rw),    64'(m_rw));
  endtask

  task automatic step(input logic st, input logic fl, input logic v,
                      input logic [31:0] a, input logic [31:0] m,
                      input logic rw, input logic m2r, input logic [4:0] wr);
    Stall = st; Flush = fl; In_Valid = v; In_ALUResult = a; In_MemReadData = m;
    In_RegWrite = rw; In_MemToReg = m2r; In_WriteReg = wr;
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_step();
    logic [4:0] wr;
    wr = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
    step($urandom_range(4) == 0, $urandom_range(9) == 0, $urandom_range(3) != 0,
         $urandom, $urandom, 1'($urandom), 1'($urandom), wr);
  endtask

  // Async reset pulse between edges; outputs must clear before the next edge.
  task automatic pulse_reset();
    #1 Reset = 0;
    #1;
    model_reset();
    check_all();
    #1 Reset = 1;
  endtask

  initial begin
    Reset = 0; Stall = 0; Flush = 0; In_Valid = 0; In_ALUResult = 0;
    In_MemReadData = 0; In_RegWrite = 0; In_MemToReg = 0; In_WriteReg = 0;
    model_reset();
    #1;
    check_all();
    In_Valid = 1; In_ALUResult = 32'hffff_ffff; In_RegWrite = 1; In_WriteReg = 5'd3;
    repeat (2) @(posedge Clk);
    #1;
    check_all();
    Reset = 1;

    // Basic load
    step(0, 0, 1, 32'h0000_1234, 32'hdead_beef, 1, 0, 5'd8);
    cmp("t2_alu", 64'(o_alu), 64'h1234);
    cmp("t2_rw",  64'(o_rw),  64'd1);
    cmp("t2_wr",  64'(o_wr),  64'd8);
    cmp("t2_cnt", 64'(o_cnt), 64'd1);

    // Write to $zero suppressed, still retires
    step(0, 0, 1, 32'h55, 32'h66, 1, 1, 5'd0);
    cmp("t3_rw",  64'(o_rw),  64'd0);
    cmp("t3_cnt", 64'(o_cnt), 64'd2);

    // Stall freezes everything while inputs churn
    for (int i = 0; i < 3; i++) step(1, 0, 1, $urandom, $urandom, 1, 0, 5'd9);
    cmp("t4_alu", 64'(o_alu), 64'h55);
    cmp("t4_cnt", 64'(o_cnt), 64'd2);
    step(0, 0, 1, 32'h77, 32'h88, 1, 0, 5'd4);
    cmp("t4_resume", 64'(o_cnt), 64'd3);

    // Invalid slot: data captured, control gated
    step(0, 0, 0, 32'habcd, 32'h1, 1, 1, 5'd3);
    cmp("inv_rw",  64'(o_rw),  64'd0);
    cmp("inv_alu", 64'(o_alu), 64'habcd);
    cmp("inv_cnt", 64'(o_cnt), 64'd3);

    // Stall+Flush: bubble, no count
    step(0, 0, 1, 32'h99, 32'h98, 1, 1, 5'd7);
    step(1, 1, 1, 32'h11, 32'h12, 1, 1, 5'd7);
    cmp("t5_valid", 64'(o_valid), 64'd0);
    cmp("t5_rw",    64'(o_rw),    64'd0);
    cmp("t5_cnt",   64'(o_cnt),   64'd4);

    // Mid-run async reset with nonzero outputs
    step(0, 0, 1, 32'h4321, 32'h5, 1, 1, 5'd12);
    pulse_reset();
    cmp("t1_alu", 64'(o_alu), 64'd0);
    cmp("t1_cnt", 64'(o_cnt), 64'd0);

    // Counter wrap on the 3-bit instance
    for (int i = 0; i < 7; i++) step(0, 0, 1, 32'(i), 32'(i), 1, 0, 5'd1);
    cmp("t6_pre", 64'(s_cnt), 64'd7);
    step(0, 0, 1, 32'h1, 32'h2, 1, 0, 5'd1);
    cmp("t6_wrap", 64'(s_cnt), 64'd0);
    cmp("t6_big",  64'(o_cnt), 64'd8);

    // Reset while stalled
    Stall = 1;
    pulse_reset();

    for (int i = 0; i < 500; i++) begin
      rand_step();
      if ($urandom_range(60) == 0) pulse_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
